// File: rtl/div_sqrt_pkg.sv
// Types and helpers shared by the radix-2 div/sqrt mantissa engine and its iteration cell.
package div_sqrt_pkg;

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic {DIV, SQRT} mode_e;

  // Clock cycles needed to produce all width+2 result bits.
  function automatic int calc_ncyc(input int width, input int iter_per_cycle);
    return (width + 2 + iter_per_cycle - 1) / iter_per_cycle;
  endfunction

  function automatic int calc_cnt_w(input int ncyc);
    return (ncyc > 1) ? $clog2(ncyc) : 1;
  endfunction

endpackage

// File: rtl/div_sqrt_iter_cell.sv
// One combinational non-restoring radix-2 step, shared by division and square root.
module div_sqrt_iter_cell
  import div_sqrt_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             en_i,
  input  mode_e            mode_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [WIDTH+4:0] rem_i,
  input  logic [WIDTH+1:0] res_i,
  input  logic [WIDTH-1:0] rad_i,
  output logic [WIDTH+4:0] rem_o,
  output logic [WIDTH+1:0] res_o,
  output logic [WIDTH-1:0] rad_o
);

  localparam int RW = WIDTH + 5;

  logic          neg;
  logic [RW-1:0] shifted;
  logic [RW-1:0] term;
  logic [RW-1:0] sum;

  assign neg = rem_i[RW-1];

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    shifted = rem_i;
    term    = {{(RW-WIDTH){1'b0}}, divisor_i};
    rem_o   = rem_i;
    res_o   = res_i;
    rad_o   = rad_i;
    // Sqrt brings in the next two radicand bits; the trial term is 4q+1 (subtract) or 4q+3 (add).
    if (mode_i == SQRT) begin
      shifted = {rem_i[RW-3:0], rad_i[WIDTH-1:WIDTH-2]};
      term    = {1'b0, res_i, neg, 1'b1};
    end
    sum = neg ? (shifted + term) : (shifted + ~term + RW'(1));
    if (en_i) begin
      // Division keeps the remainder pre-doubled so the next step needs no shift.
      rem_o = (mode_i == SQRT) ? sum : {sum[RW-2:0], 1'b0};
      res_o = {res_i[WIDTH:0], ~sum[RW-1]};
      rad_o = rad_i << 2;
    end
  end

endmodule

// File: rtl/div_sqrt_mant_iter.sv
// Multi-cycle mantissa divider / square-root engine producing truncated results plus a sticky bit.
module div_sqrt_mant_iter
  import div_sqrt_pkg::*;
#(
  parameter int WIDTH          = 24,
  parameter int ITER_PER_CYCLE = 2
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             Div_start_SI,
  input  logic             Sqrt_start_SI,
  input  logic             Kill_SI,
  input  logic [WIDTH-1:0] Operand_a_DI,
  input  logic [WIDTH-1:0] Operand_b_DI,
  output logic             Ready_SO,
  output logic             Done_SO,
  output logic [WIDTH+1:0] Result_DO,
  output logic             Sticky_SO
);

  localparam int RES_W = WIDTH + 2;
  localparam int RW    = WIDTH + 5;
  localparam int NCYC  = calc_ncyc(WIDTH, ITER_PER_CYCLE);
  localparam int CNT_W = calc_cnt_w(NCYC);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   rad_q, rad_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [RES_W-1:0]   part_q, part_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;

  logic [RW-1:0]             rem_c  [ITER_PER_CYCLE+1];
  logic [RES_W-1:0]          part_c [ITER_PER_CYCLE+1];
  logic [WIDTH-1:0]          rad_c  [ITER_PER_CYCLE+1];
  logic [ITER_PER_CYCLE-1:0] en_c;
  logic [RW-1:0]             corr;

  assign rem_c[0]  = rem_q;
  assign part_c[0] = part_q;
  assign rad_c[0]  = rad_q;

  // Cells past the last result bit are bypassed in a partial final cycle.
  always_comb begin
    en_c = '0;
    for (int j = 0; j < ITER_PER_CYCLE; j++) begin
      en_c[j] = (int'(cnt_q) * ITER_PER_CYCLE + j) < RES_W;
    end
  end

  for (genvar j = 0; j < ITER_PER_CYCLE; j++) begin : g_cell
    div_sqrt_iter_cell #(.WIDTH(WIDTH)) u_cell (
      .en_i      (en_c[j]),
      .mode_i    (mode_q),
      .divisor_i (divisor_q),
      .rem_i     (rem_c[j]),
      .res_i     (part_c[j]),
      .rad_i     (rad_c[j]),
      .rem_o     (rem_c[j+1]),
      .res_o     (part_c[j+1]),
      .rad_o     (rad_c[j+1])
    );
  end

  // One restoring correction of the final remainder; only its zero-ness is used.
  always_comb begin
    if (mode_q == DIV) begin
      corr = $signed(rem_c[ITER_PER_CYCLE]) >>> 1;
      if (corr[RW-1]) corr = corr + {{(RW-WIDTH){1'b0}}, divisor_q};
    end else begin
      corr = rem_c[ITER_PER_CYCLE];
      if (corr[RW-1]) corr = corr + {2'b00, part_c[ITER_PER_CYCLE], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    part_d    = part_q;
    result_d  = result_q;
    sticky_d  = sticky_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!Kill_SI && (Div_start_SI || Sqrt_start_SI)) begin
          state_d   = RUN;
          cnt_d     = '0;
          mode_d    = Div_start_SI ? DIV : SQRT;
          divisor_d = Operand_b_DI;
          rad_d     = Operand_a_DI;
          rem_d     = Div_start_SI ? {{(RW-WIDTH){1'b0}}, Operand_a_DI} : '0;
          part_d    = '0;
        end
      end
      RUN: begin
        if (Kill_SI) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d  = rem_c[ITER_PER_CYCLE];
          part_d = part_c[ITER_PER_CYCLE];
          rad_d  = rad_c[ITER_PER_CYCLE];
          if (cnt_q == CNT_W'(NCYC - 1)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_d   = 1'b1;
            result_d = part_c[ITER_PER_CYCLE];
            sticky_d = |corr;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q   <= IDLE;
      mode_q    <= DIV;
      cnt_q     <= '0;
      divisor_q <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      part_q    <= '0;
      result_q  <= '0;
      sticky_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      rad_q     <= rad_d;
      rem_q     <= rem_d;
      part_q    <= part_d;
      result_q  <= result_d;
      sticky_q  <= sticky_d;
      done_q    <= done_d;
    end
  end

  assign Ready_SO  = (state_q == IDLE);
  assign Done_SO   = done_q;
  assign Result_DO = result_q;
  assign Sticky_SO = sticky_q;

endmodule

// File: tb/tb_div_sqrt_mant_iter.sv
// Bench for div_sqrt_mant_iter: five unroll factors driven in lock-step against an arithmetic model.
module tb_div_sqrt_mant_iter;

  localparam int NDUT = 5;
  localparam int MAXK = 40;

  function automatic int ipc_of(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 4;
      default: return 26;
    endcase
  endfunction

  function automatic int ncyc_of(input int g);
    return (26 + ipc_of(g) - 1) / ipc_of(g);
  endfunction

  logic            Clk_CI = 1'b0;
  logic            Rst_RI;
  logic            Div_start_SI;
  logic            Sqrt_start_SI;
  logic            Kill_SI;
  logic [23:0]     Operand_a_DI;
  logic [23:0]     Operand_b_DI;
  logic [NDUT-1:0] ready;
  logic [NDUT-1:0] done;
  logic [NDUT-1:0] sticky;
  logic [25:0]     result [NDUT];

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk_CI = ~Clk_CI;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    div_sqrt_mant_iter #(.WIDTH(24), .ITER_PER_CYCLE(ipc_of(g))) u_dut (
      .Clk_CI        (Clk_CI),
      .Rst_RI        (Rst_RI),
      .Div_start_SI  (Div_start_SI),
      .Sqrt_start_SI (Sqrt_start_SI),
      .Kill_SI       (Kill_SI),
      .Operand_a_DI  (Operand_a_DI),
      .Operand_b_DI  (Operand_b_DI),
      .Ready_SO      (ready[g]),
      .Done_SO       (done[g]),
      .Result_DO     (result[g]),
      .Sticky_SO     (sticky[g])
    );
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Truncated quotient / root straight from the arithmetic definition.
  function automatic void model(input bit is_div, input logic [23:0] a, input logic [23:0] b,
                                output longint res, output bit stk);
    longint n;
    if (is_div) begin
      n   = longint'(a) << 25;
      res = n / longint'(b);
      stk = (n % longint'(b)) != 0;
    end else begin
      n   = longint'(a) << 28;
      res = longint'($sqrt(real'(n)));
      while (res * res > n) res--;
      while ((res + 1) * (res + 1) <= n) res++;
      stk = (res * res) != n;
    end
  endfunction

  task automatic issue(input bit ds, input bit ss, input logic [23:0] a, input logic [23:0] b);
    Div_start_SI  = ds;
    Sqrt_start_SI = ss;
    Operand_a_DI  = a;
    Operand_b_DI  = b;
    @(posedge Clk_CI);
    #1;
    Div_start_SI  = 1'b0;
    Sqrt_start_SI = 1'b0;
  endtask

  // Called right after issue(); k counts cycles after the accepting edge.
  task automatic wait_check(input string name, input longint exp_res, input bit exp_stk,
                            input bit glitch, input bit chk_hold, input longint hold_val);
    int          lat     [NDUT];
    int          rdy_err [NDUT];
    logic [25:0] got_res [NDUT];
    bit          got_stk [NDUT];
    bit          all_seen;
    for (int g = 0; g < NDUT; g++) begin
      lat[g] = -1; rdy_err[g] = 0; got_res[g] = '0; got_stk[g] = 1'b0;
    end
    for (int k = 0; k <= MAXK; k++) begin
      @(negedge Clk_CI);
      if (chk_hold && k == 0) check({name, "_hold"}, longint'(result[0]), hold_val);
      all_seen = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
        if (lat[g] < 0) begin
          if (done[g]) begin
            lat[g]     = k;
            got_res[g] = result[g];
            got_stk[g] = sticky[g];
            if (!ready[g]) rdy_err[g]++;
          end else begin
            if (ready[g]) rdy_err[g]++;
            all_seen = 1'b0;
          end
        end
      end
      // Start pulses with junk operands while every instance is still busy.
      if (glitch && k == 0) begin
        Div_start_SI = 1'b1; Sqrt_start_SI = 1'b1;
        Operand_a_DI = 24'h5A5A5A; Operand_b_DI = 24'h800001;
      end
      if (glitch && k == 1) begin
        Div_start_SI = 1'b0; Sqrt_start_SI = 1'b0;
      end
      if (all_seen) break;
    end
    Div_start_SI = 1'b0; Sqrt_start_SI = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("%s_lat[%0d]", name, g), longint'(lat[g]), longint'(ncyc_of(g)));
      check($sformatf("%s_res[%0d]", name, g), longint'(got_res[g]), exp_res);
      check($sformatf("%s_stk[%0d]", name, g), longint'(got_stk[g]), longint'(exp_stk));
      check($sformatf("%s_rdy[%0d]", name, g), longint'(rdy_err[g]), 0);
    end
  endtask

  task automatic model_op(input string name, input bit ds, input bit ss,
                          input logic [23:0] a, input logic [23:0] b);
    longint er;
    bit     es;
    model(ds, a, b, er, es);
    issue(ds, ss, a, b);
    wait_check(name, er, es, 1'b0, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("%s_ready[%0d]", name, g), longint'(ready[g]), 1);
      check($sformatf("%s_done[%0d]", name, g), longint'(done[g]), 0);
      check($sformatf("%s_res[%0d]", name, g), longint'(result[g]), 0);
      check($sformatf("%s_stk[%0d]", name, g), longint'(sticky[g]), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          done_cnt [NDUT];
    longint      er;
    bit          es;
    logic [23:0] a, b;
    int          sel;

    Rst_RI = 1'b1; Div_start_SI = 1'b0; Sqrt_start_SI = 1'b0; Kill_SI = 1'b0;
    Operand_a_DI = '0; Operand_b_DI = '0;
    repeat (3) @(posedge Clk_CI);
    @(negedge Clk_CI);
    check_reset_outputs("reset");
    Rst_RI = 1'b0;

    issue(1'b1, 1'b0, 24'hC00000, 24'h800000);
    wait_check("div_exact", 64'h3000000, 1'b0, 1'b0, 1'b0, 0);
    issue(1'b1, 1'b0, 24'h800000, 24'hC00000);
    wait_check("div_inexact", 64'h1555555, 1'b1, 1'b0, 1'b0, 0);
    issue(1'b0, 1'b1, 24'h900000, 24'h000000);
    wait_check("sqrt_900000", 64'h3000000, 1'b0, 1'b0, 1'b0, 0);
    issue(1'b0, 1'b1, 24'h400000, 24'h000000);
    wait_check("sqrt_400000", 64'h2000000, 1'b0, 1'b0, 1'b0, 0);

    // Both starts high must divide; the junk starts during RUN must be ignored.
    issue(1'b1, 1'b1, 24'h900000, 24'hC00000);
    wait_check("both_starts", 64'h1800000, 1'b0, 1'b1, 1'b0, 0);

    // New start in the done cycle of the slowest instance; its result must stay put.
    issue(1'b1, 1'b0, 24'hFFFFFF, 24'h800000);
    wait_check("b2b_first", 64'h3FFFFFC, 1'b0, 1'b0, 1'b0, 0);
    model(1'b0, 24'hFFFFFF, 24'h0, er, es);
    issue(1'b0, 1'b1, 24'hFFFFFF, 24'h0);
    wait_check("b2b_second", er, es, 1'b0, 1'b1, 64'h3FFFFFC);

    model_op("div_eq", 1'b1, 1'b0, 24'h800000, 24'h800000);
    model_op("div_max", 1'b1, 1'b0, 24'hFFFFFF, 24'hFFFFFF);
    model_op("div_min", 1'b1, 1'b0, 24'h800000, 24'hFFFFFF);
    model_op("sqrt_min", 1'b0, 1'b1, 24'h400000, 24'h0);
    model_op("sqrt_max", 1'b0, 1'b1, 24'hFFFFFF, 24'h0);

    // Kill during RUN cycle 5: no done from the four multi-cycle instances.
    for (int g = 0; g < NDUT; g++) done_cnt[g] = 0;
    issue(1'b1, 1'b0, 24'hABCDEF, 24'h876543);
    for (int k = 0; k <= 30; k++) begin
      @(negedge Clk_CI);
      for (int g = 0; g < NDUT - 1; g++) if (done[g]) done_cnt[g]++;
      if (k == 6) begin
        Kill_SI = 1'b0;
        for (int g = 0; g < NDUT - 1; g++)
          check($sformatf("kill_ready[%0d]", g), longint'(ready[g]), 1);
      end
      if (k == 5) Kill_SI = 1'b1;
    end
    for (int g = 0; g < NDUT - 1; g++)
      check($sformatf("kill_nodone[%0d]", g), longint'(done_cnt[g]), 0);
    model_op("after_kill", 1'b1, 1'b0, 24'h9ABCDE, 24'hC12345);

    // Kill together with a start while idle: nothing is accepted.
    for (int g = 0; g < NDUT; g++) done_cnt[g] = 0;
    Kill_SI = 1'b1;
    issue(1'b1, 1'b1, 24'hC00000, 24'h800000);
    Kill_SI = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      @(negedge Clk_CI);
      for (int g = 0; g < NDUT; g++) begin
        if (done[g]) done_cnt[g]++;
        if (k == 0) check($sformatf("killstart_ready[%0d]", g), longint'(ready[g]), 1);
      end
    end
    for (int g = 0; g < NDUT; g++)
      check($sformatf("killstart_nodone[%0d]", g), longint'(done_cnt[g]), 0);

    // Synchronous reset in the middle of an operation.
    issue(1'b0, 1'b1, 24'hE12345, 24'h0);
    for (int k = 0; k <= 3; k++) @(negedge Clk_CI);
    Rst_RI = 1'b1;
    @(negedge Clk_CI);
    check_reset_outputs("midrst");
    Rst_RI = 1'b0;
    model_op("after_rst", 1'b0, 1'b1, 24'h7FFFFF, 24'h0);

    for (int i = 0; i < 1200; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5) begin
        a = {1'b1, 23'($urandom)};
        b = {1'b1, 23'($urandom)};
        model_op("rand_div", 1'b1, sel == 0, a, b);
      end else begin
        a = 24'($urandom_range(32'h400000, 32'hFFFFFF));
        b = 24'($urandom);
        model_op("rand_sqrt", 1'b0, 1'b1, a, b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_sqrt_mant_iter.md
# div_sqrt_mant_iter

Multi-cycle mantissa engine for the div/sqrt unit. It computes the truncated quotient or square root of normalized fixed-point mantissas by non-restoring radix-2 iteration, unrolling `ITER_PER_CYCLE` iterations per clock. Results come with a sticky bit for the downstream rounding stage. The block sits between the operand preprocessing stage (special-case, exponent and parity handling) and the normalization/rounding stage; it never sees signs, exponents or special operands.

## Interface
Parameters:
- `WIDTH`, 24: mantissa width including hidden bit; result width is `WIDTH+2`.
- `ITER_PER_CYCLE`, 2: iterations unrolled per clock, 1..`WIDTH+2`.

Ports:
- `Clk_CI`  in  1  clock; all state is updated on the rising edge.
- `Rst_RI`  in  1  reset, synchronous and active-high.
- `Div_start_SI`  in  1  start a division.
- `Sqrt_start_SI`  in  1  start a square root.
- `Kill_SI`  in  1  abort the current operation.
- `Operand_a_DI`  in  `WIDTH`  dividend or radicand.
- `Operand_b_DI`  in  `WIDTH`  divisor; ignored for sqrt.
- `Ready_SO`  out  1  a start is accepted in this cycle.
- `Done_SO`  out  1  one-cycle pulse marking a valid result.
- `Result_DO`  out  `WIDTH+2`  quotient or root.
- `Sticky_SO`  out  1  final partial remainder is nonzero.

## Operation
- Define NCYC = ceil((`WIDTH`+2)/`ITER_PER_CYCLE`).
- **FSM states:**
  - IDLE → RUN when the start is accepted.
  - RUN → IDLE after NCYC cycles, asserting `Done_SO`.
  - RUN → IDLE on `Kill_SI`, with no `Done_SO`.
- **Start acceptance:**
  - A start is accepted when `Ready_SO` is high and either start input is high.
  - If both starts are high, the operation is a division.
  - At acceptance the operands and mode are registered; the sqrt/div mode is held for the whole operation.
  - Starts while in RUN are ignored, and the operands are not resampled.
- **Division:**
  - Requires `Operand_a_DI[WIDTH-1]`=1 and `Operand_b_DI[WIDTH-1]`=1.
  - Result = floor(A·2^(WIDTH+1)/B).
  - Sticky = (A·2^(WIDTH+1) mod B ≠ 0).
- **Square root:**
  - Requires A ≥ 2^(WIDTH-2), so the caller may pre-shift A right by one for odd exponents.
  - Result = floor(sqrt(A·2^(WIDTH+4))).
  - Sticky = (A·2^(WIDTH+4) ≠ Result²).
- **Iteration step:**
  - Each step adds or subtracts (carry-in 1 on subtract) the divisor, or the partial-root term, according to the sign of the previous partial remainder.
  - It emits one result bit.
  - The final remainder is corrected once for the sticky computation only.
- **Partial last cycle:** if `WIDTH+2` is not a multiple of `ITER_PER_CYCLE`, the last RUN cycle enables only the remaining iterations; the extra cells are bypassed.
- **Invalid operands:** inputs violating the normalization rules give undefined `Result_DO` and `Sticky_SO`, but latency and handshake are unchanged.

## Timing
- **Reset values:** FSM IDLE, `Ready_SO`=1, `Done_SO`=0, `Result_DO`=0, `Sticky_SO`=0, iteration counter 0.
- **Latency:** a start accepted at edge t gives `Done_SO`=1 during cycle t+NCYC. `Result_DO` and `Sticky_SO` are valid from that cycle and held until the next accepted start's first update.
- **Ready:** `Ready_SO`=0 through the RUN cycles and returns to 1 in the `Done_SO` cycle. A back-to-back start in the `Done_SO` cycle is accepted, and that cycle's result remains valid.
- **Kill:**
  - `Kill_SI` in RUN returns to IDLE at the next edge, with no `Done_SO`.
  - `Result_DO` keeps whatever value it held; it is not guaranteed.
  - `Kill_SI` and a start in the same IDLE cycle: the kill wins and no start is accepted.
- **Reset mid-operation:** applies all reset values at the next edge, with no `Done_SO`.
- **Counter:** counts 0..NCYC-1 and wraps to 0 on completion or kill.

## Structure
- **Shared package `div_sqrt_pkg`:**
  - the state enum (IDLE, RUN);
  - the function computing NCYC from `WIDTH` and `ITER_PER_CYCLE`;
  - the mode typedef (DIV, SQRT).
- **Sub-module `div_sqrt_iter_cell`:**
  - parametrised `WIDTH`;
  - one combinational non-restoring step: add/subtract, carry-in, next quotient/root bit;
  - instantiated `ITER_PER_CYCLE` times in a generate chain, each with an enable for the partial last cycle.
- **Top level:** the FSM, counter, operand/remainder/result registers and sticky logic.

## Test plan
- **Division, exact:** `WIDTH`=24, `ITER_PER_CYCLE`=1, div A=0xC00000 B=0x800000 → `Done_SO` 26 cycles after start, Result=0x3000000, Sticky=0.
- **Division, inexact:** `WIDTH`=24, `ITER_PER_CYCLE`=2, div A=0x800000 B=0xC00000 → Done after 13 cycles, Result=0x1555555, Sticky=1.
- **Square root:** `WIDTH`=24, `ITER_PER_CYCLE`=4, sqrt A=0x900000 → Done after 7 cycles (last cycle 2 iterations), Result=0x3000000, Sticky=0. Then sqrt A=0x400000 → Result=0x2000000, Sticky=0.
- **Handshake and priority:**
  - Start issued in the Done cycle → accepted, and the prior result is still read correctly.
  - Start pulses during RUN → ignored.
  - Both starts high → a division is performed.
- **Kill and reset:**
  - `Kill_SI` at RUN cycle 5 → no Done, `Ready_SO`=1 next cycle, and a new op completes with the correct result.
  - `Rst_RI` mid-RUN → all outputs at their reset values.
- **Random check:** 10k random normalized operands for both modes against a reference model, for `ITER_PER_CYCLE` in {1,2,3,26}.
